// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR over WIDTH bits, with the log2(WIDTH)
// mux levels spread across STAGES registered stages under one global advance signal.
module shifter_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 5,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero,
    output logic                     out_illegal
);

    localparam int unsigned SW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_e;

    // Level lvl belongs to this stage: the first (SW % STAGES) stages take one extra level.
    function automatic int unsigned stage_of(input int unsigned lvl);
        int unsigned hi;
        int unsigned lo;
        int unsigned rem;
        int unsigned bnd;
        hi  = (SW + STAGES - 1) / STAGES;
        lo  = SW / STAGES;
        rem = SW % STAGES;
        bnd = rem * hi;
        if (lvl < bnd) return lvl / hi;
        return rem + (lvl - bnd) / lo;
    endfunction

    function automatic logic bit_at(input logic [SW-1:0] v, input int unsigned idx);
        logic [SW-1:0] t;
        t = v >> idx;
        return t[0];
    endfunction

    // One mux level: shift by 2^lvl; SRA fills from the sign bit captured at acceptance.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             sign,
        input int unsigned      lvl
    );
        int unsigned      k;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] fill;
        k    = 1 << lvl;
        ones = '1;
        fill = sign ? ~(ones >> k) : '0;
        case (op)
            OP_SLL:  return d << k;
            OP_SRL:  return d >> k;
            OP_SRA:  return (d >> k) | fill;
            OP_ROL:  return (d << k) | (d >> (WIDTH - k));
            OP_ROR:  return (d >> k) | (d << (WIDTH - k));
            default: return d;
        endcase
    endfunction

    logic                 valid_q [STAGES];
    logic [WIDTH-1:0]     data_q  [STAGES];
    logic [SW-1:0]        shamt_q [STAGES];
    logic [2:0]           op_q    [STAGES];
    logic                 sign_q  [STAGES];
    logic [TAG_W-1:0]     tag_q   [STAGES];
    logic                 zero_q;

    logic                 nxt_valid [STAGES];
    logic [WIDTH-1:0]     nxt_data  [STAGES];
    logic [SW-1:0]        nxt_shamt [STAGES];
    logic [2:0]           nxt_op    [STAGES];
    logic                 nxt_sign  [STAGES];
    logic [TAG_W-1:0]     nxt_tag   [STAGES];
    logic                 nxt_zero;

    logic adv;

    assign out_valid   = valid_q[STAGES-1];
    assign adv         = !out_valid || out_ready;
    assign in_ready    = adv;
    assign out_data    = data_q[STAGES-1];
    assign out_tag     = tag_q[STAGES-1];
    assign out_zero    = zero_q;
    assign out_illegal = op_q[STAGES-1] > 3'd4;

    always_comb begin
        nxt_valid[0] = in_valid;
        nxt_data[0]  = in_data;
        nxt_shamt[0] = in_shamt;
        nxt_op[0]    = in_op;
        nxt_sign[0]  = in_data[WIDTH-1];
        nxt_tag[0]   = in_tag;
        for (int unsigned s = 1; s < STAGES; s++) begin
            nxt_valid[s] = valid_q[s-1];
            nxt_data[s]  = data_q[s-1];
            nxt_shamt[s] = shamt_q[s-1];
            nxt_op[s]    = op_q[s-1];
            nxt_sign[s]  = sign_q[s-1];
            nxt_tag[s]   = tag_q[s-1];
        end
        for (int unsigned s = 0; s < STAGES; s++) begin
            for (int unsigned i = 0; i < SW; i++) begin
                if (stage_of(i) == s && bit_at(nxt_shamt[s], i)) begin
                    nxt_data[s] = shift_level(nxt_data[s], nxt_op[s], nxt_sign[s], i);
                end
            end
        end
        nxt_zero = (nxt_data[STAGES-1] == '0);
    end

    // Flush kills valid bits unconditionally; payload registers only move on adv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
                data_q[s]  <= '0;
                shamt_q[s] <= '0;
                op_q[s]    <= '0;
                sign_q[s]  <= 1'b0;
                tag_q[s]   <= '0;
            end
            zero_q <= 1'b0;
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                if (flush) begin
                    valid_q[s] <= 1'b0;
                end else if (adv) begin
                    valid_q[s] <= nxt_valid[s];
                end
                if (adv) begin
                    data_q[s]  <= nxt_data[s];
                    shamt_q[s] <= nxt_shamt[s];
                    op_q[s]    <= nxt_op[s];
                    sign_q[s]  <= nxt_sign[s];
                    tag_q[s]   <= nxt_tag[s];
                end
            end
            if (adv) begin
                zero_q <= nxt_zero;
            end
        end
    end

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe: directed vectors, stall, flush, mid-flight reset, random burst.
module tb_shifter_pipe;

    parameter int unsigned WIDTH  = 32;
    parameter int unsigned STAGES = 5;
    parameter int unsigned TAG_W  = 5;
    localparam int unsigned SW = $clog2(WIDTH);

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SW-1:0]        in_shamt;
    logic [2:0]           in_op;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_zero;
    logic                 out_illegal;

    shifter_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_zero(out_zero), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             ill;
        logic             lat;
        int unsigned      acc;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Independent reference: whole-word shifts, rotates via a doubled operand.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d,
                                               input logic [SW-1:0] sh,
                                               input logic [2:0] op);
        logic [2*WIDTH-1:0]  dd;
        logic signed [WIDTH-1:0] sd;
        dd = {d, d};
        sd = d;
        case (op)
            3'd0: return d << sh;
            3'd1: return d >> sh;
            3'd2: return sd >>> sh;
            3'd3: begin dd = dd << sh; return dd[2*WIDTH-1:WIDTH]; end
            3'd4: begin dd = dd >> sh; return dd[WIDTH-1:0]; end
            default: return d;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] pick(input logic [31:0] c32, input logic [WIDTH-1:0] d,
                                              input logic [SW-1:0] sh, input logic [2:0] op);
        if (WIDTH == 32) return WIDTH'(c32);
        return model(d, sh, op);
    endfunction

    function automatic void push(input logic [WIDTH-1:0] exp, input logic [TAG_W-1:0] tg,
                                 input logic [2:0] op, input logic lat);
        exp_t e;
        e.data = exp;
        e.tag  = tg;
        e.zero = (exp == '0);
        e.ill  = (op > 3'd4);
        e.lat  = lat;
        e.acc  = cyc;
        q.push_back(e);
    endfunction

    // Monitor: retire-side pop and compare; flush/reset discard in-flight expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("expected_output", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("data", 64'(out_data), 64'(e.data));
                    chk("tag", 64'(out_tag), 64'(e.tag));
                    chk("zero", 64'(out_zero), 64'(e.zero));
                    chk("illegal", 64'(out_illegal), 64'(e.ill));
                    if (e.lat) chk("latency", 64'(cyc), 64'(e.acc + STAGES));
                end
            end
            if (flush) q.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] d, input int unsigned sh,
                         input logic [TAG_W-1:0] tg, input logic [WIDTH-1:0] exp, input logic lat);
        int unsigned tries;
        bit done;
        tries = 0;
        done = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = SW'(sh);
        in_tag   = tg;
        while (!done) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                push(exp, tg, op, lat);
                done = 1;
            end
            step();
            tries++;
            if (!done && tries > 50) begin
                chk("issue_timeout", 64'd0, 64'd1);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) step();
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] snap_d;
        logic [TAG_W-1:0] snap_t;
        logic snap_z, snap_i;
        int unsigned sent, stall, seen;
        bit stall_done;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_shamt = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        rst_n = 1'b1;
        step();
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Directed vectors; first two of the SRA/SRL pair go back-to-back.
        d = WIDTH'(32'h00000001);
        issue(3'd0, d, 31, 5'd7, pick(32'h80000000, d, SW'(31), 3'd0), 1'b1);
        drain();
        d = WIDTH'(32'h80000000) << (WIDTH - 32 > 0 ? 0 : 0);
        if (WIDTH != 32) d = {1'b1, {(WIDTH-1){1'b0}}};
        issue(3'd2, d, 4, 5'd1, pick(32'hF8000000, d, SW'(4), 3'd2), 1'b1);
        issue(3'd1, d, 4, 5'd2, pick(32'h08000000, d, SW'(4), 3'd1), 1'b1);
        drain();
        d = WIDTH'(32'h000000FF);
        issue(3'd4, d, 4, 5'd3, pick(32'hF000000F, d, SW'(4), 3'd4), 1'b1);
        d = WIDTH'(32'h80000001);
        if (WIDTH != 32) d = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
        issue(3'd3, d, 1, 5'd4, pick(32'h00000003, d, SW'(1), 3'd3), 1'b1);
        d = WIDTH'(32'h12345678);
        issue(3'd0, d, 0, 5'd5, pick(32'h12345678, d, SW'(0), 3'd0), 1'b1);
        d = WIDTH'(32'h00000001);
        issue(3'd1, d, 1, 5'd6, pick(32'h00000000, d, SW'(1), 3'd1), 1'b1);
        d = WIDTH'(32'hDEADBEEF);
        issue(3'd6, d, 3, 5'd8, pick(32'hDEADBEEF, d, SW'(3), 3'd6), 1'b1);
        issue(3'd5, d, 1, 5'd9, model(d, SW'(1), 3'd5), 1'b1);
        issue(3'd7, '0, 2, 5'd10, '0, 1'b1);
        drain();

        // Streaming with a 3-cycle consumer stall once six ops are accepted.
        sent = 0; stall = 0; stall_done = 0;
        snap_d = '0; snap_t = '0; snap_z = 1'b0; snap_i = 1'b0;
        for (int g = 0; g < 100 && sent < 8; g++) begin
            if (sent == 6 && !stall_done) begin stall = 3; stall_done = 1; end
            out_ready = (stall == 0);
            r = {$urandom(), $urandom()};
            in_valid = 1'b1;
            in_op    = 3'(sent % 5);
            in_data  = r[WIDTH-1:0] ^ WIDTH'(sent);
            in_shamt = SW'(sent * 3 + 1);
            in_tag   = TAG_W'(sent);
            @(negedge clk);
            if (stall != 0) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                if (stall == 3) begin
                    chk("stall_out_valid", 64'(out_valid), 64'd1);
                    snap_d = out_data; snap_t = out_tag; snap_z = out_zero; snap_i = out_illegal;
                end else begin
                    chk("stable_data", 64'(out_data), 64'(snap_d));
                    chk("stable_tag", 64'(out_tag), 64'(snap_t));
                    chk("stable_zero", 64'(out_zero), 64'(snap_z));
                    chk("stable_illegal", 64'(out_illegal), 64'(snap_i));
                end
                stall--;
            end
            if (in_ready) begin
                push(model(in_data, in_shamt, in_op), in_tag, in_op, 1'b0);
                sent++;
            end
            step();
        end
        chk("stream_sent", 64'(sent), 64'd8);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Flush with a request in the same cycle: nothing in flight may emerge.
        for (int k = 0; k < 3; k++) begin
            r = {$urandom(), $urandom()};
            issue(3'(k), r[WIDTH-1:0], k + 1, TAG_W'(11 + k), model(r[WIDTH-1:0], SW'(k + 1), 3'(k)), 1'b0);
        end
        in_valid = 1'b1; in_op = 3'd0; in_data = '1; in_shamt = SW'(1); in_tag = TAG_W'(20);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        d = WIDTH'(32'h0000F0F0);
        issue(3'd1, d, 4, 5'd14, model(d, SW'(4), 3'd1), 1'b1);
        drain();

        // Reset mid-flight: outputs clear at once and no result appears after release.
        for (int k = 0; k < 3; k++) begin
            r = {$urandom(), $urandom()};
            issue(3'd3, r[WIDTH-1:0], k + 2, TAG_W'(21 + k), model(r[WIDTH-1:0], SW'(k + 2), 3'd3), 1'b0);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        chk("midrst_out_tag", 64'(out_tag), 64'd0);
        step(); step();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
            step();
        end
        chk("post_reset_quiet", 64'(seen), 64'd0);

        // Random burst with a random consumer.
        sent = 0;
        r = {$urandom(), $urandom()};
        in_op = 3'($urandom_range(0, 7)); in_data = r[WIDTH-1:0];
        in_shamt = SW'($urandom()); in_tag = TAG_W'($urandom());
        for (int g = 0; g < 400 && sent < 24; g++) begin
            in_valid = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                push(model(in_data, in_shamt, in_op), in_tag, in_op, 1'b0);
                sent++;
                step();
                r = {$urandom(), $urandom()};
                in_op = 3'($urandom_range(0, 7)); in_data = r[WIDTH-1:0];
                in_shamt = SW'($urandom()); in_tag = TAG_W'($urandom());
            end else begin
                step();
            end
        end
        chk("burst_sent", 64'(sent), 64'd24);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
